// File: rtl/branch_predictor.sv
// Fetch-stage branch target buffer with 2-bit saturating direction counters.
//
// mux_types_pkg (in this file) defines predMux, the PC-select encoding shared
// with the PC-select logic: OPC = take PC+4, PPC = take the predicted target.
//
// branch_predictor ports:
//   CLK, RST          core clock; synchronous active-high reset
//   fetch_pc          PC being fetched (word aligned)
//   pred_sel          OPC / PPC select for the PC mux (combinational)
//   pred_target       predicted target of fetch_pc, 0 on a miss (combinational)
//   res_valid         a branch resolves in execute this cycle
//   res_pc, res_npc   PC of the resolving branch and res_pc + 4
//   res_taken         actual branch outcome
//   res_target        actual taken target
//   res_pred          prediction that was used for this branch
//   res_pred_target   target that was used when res_pred = PPC
//   flush             misprediction; younger stages must be squashed
//   fix_pc            corrected next PC, 0 when res_valid = 0
//   branch_count      resolved branches since reset (saturating)
//   mispredict_count  mispredictions since reset (saturating)
//
// Resolution interface: res_valid is a single-cycle qualifier with no
// back-pressure; every cycle it is high, the res_* fields describe exactly
// one branch and are consumed on that clock edge.

package mux_types_pkg;
  typedef enum logic {
    OPC = 1'b0,
    PPC = 1'b1
  } predMux;
endpackage

module branch_predictor
  import mux_types_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] fetch_pc,
  output predMux      pred_sel,
  output logic [31:0] pred_target,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic [31:0] res_npc,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  input  predMux      res_pred,
  input  logic [31:0] res_pred_target,
  output logic        flush,
  output logic [31:0] fix_pc,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int IDX = $clog2(ENTRIES);
  localparam int TW  = 30 - IDX;

  logic            valid_q  [ENTRIES];
  logic [TW-1:0]   tag_q    [ENTRIES];
  logic [31:0]     target_q [ENTRIES];
  logic [1:0]      ctr_q    [ENTRIES];
  logic [31:0]     branch_q;
  logic [31:0]     mispred_q;

  // Byte-offset bits of both PCs carry no information for word-aligned code.
  logic            unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[1:0], res_pc[1:0]};

  // Fetch-side lookup
  logic [IDX-1:0]  f_idx;
  logic [TW-1:0]   f_tag;
  logic            f_hit;

  assign f_idx = fetch_pc[IDX+1:2];
  assign f_tag = fetch_pc[31:IDX+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  assign pred_sel    = (f_hit && ctr_q[f_idx][1]) ? PPC : OPC;
  assign pred_target = f_hit ? target_q[f_idx] : 32'd0;

  // Resolution-side lookup and misprediction detection
  logic [IDX-1:0]  r_idx;
  logic [TW-1:0]   r_tag;
  logic            r_hit;
  logic            used_ppc;

  assign r_idx    = res_pc[IDX+1:2];
  assign r_tag    = res_pc[31:IDX+2];
  assign r_hit    = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
  assign used_ppc = (res_pred == PPC);

  // Wrong direction, or right direction (taken) but jumped to a stale target.
  assign flush  = res_valid &&
                  ((used_ppc != res_taken) ||
                   (used_ppc && res_taken && (res_pred_target != res_target)));
  assign fix_pc = !res_valid ? 32'd0 : (res_taken ? res_target : res_npc);

  // Next-state for the indexed entry's counter
  logic [1:0]      ctr_d;

  always_comb begin
    ctr_d = ctr_q[r_idx];
    if (res_taken) begin
      if (ctr_q[r_idx] != 2'b11) ctr_d = ctr_q[r_idx] + 2'd1;
    end else begin
      if (ctr_q[r_idx] != 2'b00) ctr_d = ctr_q[r_idx] - 2'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= 2'b01;
      end
      branch_q  <= 32'd0;
      mispred_q <= 32'd0;
    end else if (res_valid) begin
      if (r_hit) begin
        ctr_q[r_idx] <= ctr_d;
        if (res_taken) target_q[r_idx] <= res_target;
      end else if (res_taken) begin
        // Allocation evicts whatever alias occupied this index.
        valid_q[r_idx]  <= 1'b1;
        tag_q[r_idx]    <= r_tag;
        target_q[r_idx] <= res_target;
        ctr_q[r_idx]    <= 2'b10;
      end
      if (branch_q != 32'hFFFF_FFFF) branch_q <= branch_q + 32'd1;
      if (flush && (mispred_q != 32'hFFFF_FFFF)) mispred_q <= mispred_q + 32'd1;
    end
  end

  assign branch_count     = branch_q;
  assign mispredict_count = mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor (ENTRIES = 16).
module tb_branch_predictor;
  import mux_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] fetch_pc;
  predMux      pred_sel;
  logic [31:0] pred_target;
  logic        res_valid;
  logic [31:0] res_pc;
  logic [31:0] res_npc;
  logic        res_taken;
  logic [31:0] res_target;
  predMux      res_pred;
  logic [31:0] res_pred_target;
  logic        flush;
  logic [31:0] fix_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int nvec = 0;
  int nerr = 0;

  branch_predictor #(.ENTRIES(16)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .fetch_pc         (fetch_pc),
    .pred_sel         (pred_sel),
    .pred_target      (pred_target),
    .res_valid        (res_valid),
    .res_pc           (res_pc),
    .res_npc          (res_npc),
    .res_taken        (res_taken),
    .res_target       (res_target),
    .res_pred         (res_pred),
    .res_pred_target  (res_pred_target),
    .flush            (flush),
    .fix_pc           (fix_pc),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  // Clock
  always #5 CLK = ~CLK;

  // Inputs change 1 ns after the rising edge; checks run 3 ns after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_pred(input string tag, input predMux sel, input logic [31:0] tgt);
    chk({tag, ".sel"}, {31'd0, pred_sel}, {31'd0, sel});
    chk({tag, ".tgt"}, pred_target, tgt);
  endtask

  task automatic chk_fix(input string tag, input logic fl, input logic [31:0] pc);
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, fl});
    chk({tag, ".fix"}, fix_pc, pc);
  endtask

  task automatic chk_counts(input string tag, input logic [31:0] b, input logic [31:0] m);
    chk({tag, ".branches"}, branch_count, b);
    chk({tag, ".mispred"}, mispredict_count, m);
  endtask

  // Driver tasks
  task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                         input predMux pred, input logic [31:0] ptgt);
    res_valid       = 1'b1;
    res_pc          = pc;
    res_npc         = pc + 32'd4;
    res_taken       = taken;
    res_target      = tgt;
    res_pred        = pred;
    res_pred_target = ptgt;
  endtask

  task automatic idle();
    res_valid       = 1'b0;
    res_pc          = 32'd0;
    res_npc         = 32'd0;
    res_taken       = 1'b0;
    res_target      = 32'd0;
    res_pred        = OPC;
    res_pred_target = 32'd0;
  endtask

  initial begin
    RST      = 1'b1;
    fetch_pc = 32'd0;
    idle();
    tick();

    // Reset: sweep lookups while reset is held
    for (int a = 0; a <= 32'h7C; a += 4) begin
      fetch_pc = a;
      settle();
      chk_pred("reset_sweep", OPC, 32'd0);
      tick();
    end
    chk_counts("reset", 32'd0, 32'd0);
    settle();
    chk_fix("reset_idle", 1'b0, 32'd0);
    RST = 1'b0;
    tick();

    // Cold taken branch, fetching the same index in the same cycle
    fetch_pc = 32'h40;
    resolve(32'h40, 1'b1, 32'h100, OPC, 32'd0);
    settle();
    chk_fix("cold", 1'b1, 32'h100);
    chk_pred("cold_same_cycle", OPC, 32'd0);
    tick();
    idle();
    settle();
    chk_pred("cold_next", PPC, 32'h100);
    chk_counts("cold", 32'd1, 32'd1);
    chk_fix("idle_after_cold", 1'b0, 32'd0);

    // Saturate: three correctly predicted taken resolutions
    for (int k = 0; k < 3; k++) begin
      resolve(32'h40, 1'b1, 32'h100, PPC, 32'h100);
      settle();
      chk_fix("taken_ok", 1'b0, 32'h100);
      tick();
    end
    idle();
    settle();
    chk_counts("saturate", 32'd4, 32'd1);

    // Hysteresis: first not-taken leaves counter at weak taken
    resolve(32'h40, 1'b0, 32'h100, PPC, 32'h100);
    settle();
    chk_fix("nt1", 1'b1, 32'h44);
    tick();
    idle();
    settle();
    chk_pred("nt1_next", PPC, 32'h100);
    resolve(32'h40, 1'b0, 32'h100, PPC, 32'h100);
    settle();
    chk_fix("nt2", 1'b1, 32'h44);
    tick();
    idle();
    settle();
    chk_pred("nt2_next", OPC, 32'h100);
    chk_counts("hysteresis", 32'd6, 32'd3);

    // Retrain 0x40 to taken (counter 01 -> 10)
    resolve(32'h40, 1'b1, 32'h100, OPC, 32'd0);
    settle();
    chk_fix("retrain", 1'b1, 32'h100);
    tick();
    idle();
    settle();
    chk_pred("retrain_next", PPC, 32'h100);

    // Aliasing: 0x80 shares index 0 with 0x40 but has a different tag
    fetch_pc = 32'h80;
    settle();
    chk_pred("alias_miss", OPC, 32'd0);
    resolve(32'h80, 1'b1, 32'h300, OPC, 32'd0);
    settle();
    chk_fix("alias_alloc", 1'b1, 32'h300);
    tick();
    idle();
    settle();
    chk_pred("alias_new", PPC, 32'h300);
    fetch_pc = 32'h40;
    settle();
    chk_pred("alias_evicted", OPC, 32'd0);
    chk_counts("alias", 32'd8, 32'd5);

    // Target mismatch: bring 0x40 back to counter 11 with target 0x100
    resolve(32'h40, 1'b1, 32'h100, OPC, 32'd0);
    tick();
    resolve(32'h40, 1'b1, 32'h100, PPC, 32'h100);
    settle();
    chk_fix("tm_setup", 1'b0, 32'h100);
    tick();
    resolve(32'h40, 1'b1, 32'h200, PPC, 32'h100);
    settle();
    chk_fix("tm", 1'b1, 32'h200);
    tick();
    idle();
    settle();
    chk_pred("tm_next", PPC, 32'h200);
    chk_counts("tm", 32'd11, 32'd7);

    // Miss and not taken, predicted not taken: no flush, no allocation
    fetch_pc = 32'h10;
    resolve(32'h10, 1'b0, 32'h500, OPC, 32'd0);
    settle();
    chk_fix("nt_miss", 1'b0, 32'h14);
    tick();
    idle();
    settle();
    chk_pred("nt_miss_next", OPC, 32'd0);
    chk_counts("nt_miss", 32'd12, 32'd7);

    // Reset pulse, then same-cycle update and lookup on a cold entry
    RST = 1'b1;
    tick();
    RST = 1'b0;
    fetch_pc = 32'h40;
    settle();
    chk_pred("post_reset", OPC, 32'd0);
    chk_counts("post_reset", 32'd0, 32'd0);
    resolve(32'h40, 1'b1, 32'h100, OPC, 32'd0);
    settle();
    chk_pred("same_cycle", OPC, 32'd0);
    tick();
    idle();
    settle();
    chk_pred("same_cycle_next", PPC, 32'h100);
    chk_counts("same_cycle", 32'd1, 32'd1);

    // Reset dominates a concurrent resolution
    RST = 1'b1;
    resolve(32'h40, 1'b1, 32'h100, OPC, 32'd0);
    tick();
    RST = 1'b0;
    idle();
    settle();
    chk_pred("rst_dominates", OPC, 32'd0);
    chk_counts("rst_dominates", 32'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Hard time limit so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage branch target buffer with 2-bit saturating direction counters for the pipelined MIPS core. It supplies the `predMux` select and the predicted target to the PC-select logic every cycle. It takes branch resolutions from the execute stage and flags mispredictions together with the corrected PC. It also keeps branch and misprediction statistics counters.

## Interface
Parameters:
- `ENTRIES`, 16, number of direct-mapped BTB entries; must be a power of two, at least 2. `IDX = log2(ENTRIES)`.

Ports (types from `mux_types_pkg`):
- `CLK  in  1  core clock; all state updates on the rising edge`
- `RST  in  1  reset; synchronous, active-high`
- `fetch_pc  in  32  PC being fetched (word aligned)`
- `pred_sel  out  predMux  OPC = take PC+4, PPC = take pred_target`
- `pred_target  out  32  predicted target of the fetch_pc entry`
- `res_valid  in  1  a branch resolves in execute this cycle`
- `res_pc  in  32  PC of the resolving branch`
- `res_npc  in  32  res_pc + 4`
- `res_taken  in  1  actual branch outcome`
- `res_target  in  32  actual taken target`
- `res_pred  in  predMux  prediction that was used for this branch`
- `res_pred_target  in  32  target that was used when res_pred = PPC`
- `flush  out  1  misprediction; younger stages must be squashed`
- `fix_pc  out  32  corrected next PC, meaningful when flush = 1`
- `branch_count  out  32  resolved branches since reset`
- `mispredict_count  out  32  mispredictions since reset`

## Operation
- Address split: `index = pc[IDX+1:2]`, `tag = pc[31:IDX+2]`. Bits `pc[1:0]` are ignored.
- Each entry holds `valid`, `tag`, a 32-bit `target` and a 2-bit counter. Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Lookup (combinational):
  - `hit = valid & (tag match)`.
  - `pred_sel = PPC` iff `hit & counter[1]`, else `OPC`.
  - `pred_target` = entry target on a hit, else 0.
- Mispredict (combinational): `flush = res_valid & ((res_pred==PPC) != res_taken | (res_pred==PPC & res_taken & res_pred_target != res_target))`.
- `fix_pc = res_taken ? res_target : res_npc`. It is driven whenever `res_valid` is high and is 0 otherwise.
- Update, on the clock edge when `res_valid & ~RST`:
  - Hit on `res_pc`: the counter increments if taken and decrements if not, saturating at 11 and 00. If taken, the target is overwritten with `res_target`.
  - Miss and taken: allocate the entry, replacing any alias. Set valid=1, tag, target=`res_target`, counter=10.
  - Miss and not taken: no change.
- Statistics:
  - `branch_count` increments on each `res_valid`.
  - `mispredict_count` increments when `flush = 1`.
  - Both saturate at 32'hFFFF_FFFF.
- Reset: all entries valid=0, counter=01, target=0; both statistics counters = 0.

## Timing
- Lookup has zero latency: `pred_sel`/`pred_target` follow `fetch_pc` in the same cycle.
- `flush`/`fix_pc` have zero latency from the resolution inputs.
- A table update is visible to lookups starting the cycle after the edge on which it is written.
- Same-index lookup and update in one cycle: the lookup returns the pre-update state. There is no bypass.
- `RST` dominates: an edge with `RST = 1` and `res_valid = 1` performs no update and leaves the statistics at 0.
- Reset output values:
  - `pred_sel = OPC`, `pred_target = 0` for any `fetch_pc`.
  - `branch_count = mispredict_count = 0`.
  - `flush` and `fix_pc` depend only on the current inputs; both are 0 when `res_valid = 0`.
- The statistics outputs are registered and reflect the count including the previous edge.

## Test plan
- **Reset:** assert `RST`, then sweep `fetch_pc` over 0x0–0x7C → `pred_sel = OPC` and `pred_target = 0` every cycle; both counts are 0.
- **Cold taken branch:** resolve `res_pc = 0x40`, taken, `res_target = 0x100`, `res_pred = OPC`.
  - Same cycle: `flush = 1`, `fix_pc = 0x100`.
  - Next cycle, `fetch_pc = 0x40`: `pred_sel = PPC`, `pred_target = 0x100`.
  - Counts: branch 1, mispredict 1.
- **Saturation/hysteresis:** from the previous state, resolve 0x40 taken ×3 → counter 11.
  - Not-taken ×1 → `pred_sel` stays PPC (counter 10).
  - A second not-taken → `pred_sel = OPC`.
  - Each not-taken resolved with `res_pred = PPC` gives `flush = 1`, `fix_pc = 0x44`.
- **Aliasing (ENTRIES = 16):** with 0x40 trained to PPC, look up 0x80 → OPC (tag mismatch).
  - Resolve 0x80 taken to 0x300 → next cycle, 0x80 predicts PPC/0x300 and 0x40 predicts OPC.
- **Target mismatch:** entry 0x40 → 0x100 at counter 11; resolve taken, `res_target = 0x200`, `res_pred = PPC`, `res_pred_target = 0x100`.
  - Same cycle: `flush = 1`, `fix_pc = 0x200`.
  - Next cycle: `pred_target = 0x200`.
- **Same-cycle update and lookup, then reset:**
  - Cold 0x40 resolved taken while `fetch_pc = 0x40` → OPC that cycle, PPC the next.
  - Then assert `RST` with `res_valid = 1` → next cycle OPC and both counts 0.
